// File: rtl/axis_spm_offset_slew_nch.sv
// N-channel offset slew stage: rate-limited per-channel offsets with settle tracking,
// added to the streamed input plus optional lock-in modulation, saturated to symmetric full scale.
module axis_spm_offset_slew_nch #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int RDECI = 5,
  parameter int MODW  = 25,
  parameter int MODQ  = 24
) (
  input  logic              a_clk,
  input  logic              a_rst,
  input  logic [NCH*DW-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic [NCH*DW-1:0] target,
  input  logic [NCH*DW-1:0] step,
  input  logic              hold,
  input  logic [MODW-1:0]   mod_sin,
  input  logic [31:0]       mod_volume,
  input  logic [NCH-1:0]    mod_mask,
  output logic [NCH*DW-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic [NCH*DW-1:0] offset_mon,
  output logic [NCH-1:0]    moving,
  output logic [NCH-1:0]    done,
  output logic              all_settled
);

  typedef enum logic {ST_SETTLED = 1'b0, ST_MOVING = 1'b1} state_t;

  localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [DW+1:0] SAT_MIN = -SAT_MAX;

  logic w_tick;

  generate
    if (RDECI == 0) begin : g_nodeci
      assign w_tick = 1'b1;
    end else begin : g_deci
      logic [RDECI-1:0] r_cnt;
      always_ff @(posedge a_clk) begin
        if (a_rst) r_cnt <= '0;
        else       r_cnt <= r_cnt + RDECI'(1);
      end
      assign w_tick = &r_cnt;
    end
  endgenerate

  // Stream semantics: s_axis_tvalid only qualifies capture into r_in; there is no
  // tready, the sink must accept every beat, and m_axis_tvalid is tvalid delayed two clocks.
  logic signed [MODW-1:0]   w_mv;
  logic signed [2*MODW-1:0] w_mv_e;
  logic signed [2*MODW-1:0] w_sin_e;
  logic signed [2*MODW-1:0] r_prod;
  logic signed [DW-1:0]     r_mod;
  logic [NCH*DW-1:0]        r_in;
  logic [1:0]               r_vld;
  logic                     w_unused_vol;

  assign w_mv         = mod_volume[31 -: MODW];
  assign w_unused_vol = ^mod_volume[31-MODW:0];
  assign w_mv_e       = {{MODW{w_mv[MODW-1]}}, w_mv};
  assign w_sin_e      = {{MODW{mod_sin[MODW-1]}}, mod_sin};

  always_ff @(posedge a_clk) begin
    if (a_rst) begin
      r_prod <= '0;
      r_mod  <= '0;
      r_in   <= '0;
      r_vld  <= '0;
    end else begin
      r_prod <= w_mv_e * w_sin_e;
      r_mod  <= DW'(r_prod >>> MODQ);
      if (s_axis_tvalid) r_in <= s_axis_tdata;
      r_vld  <= {r_vld[0], s_axis_tvalid};
    end
  end

  assign m_axis_tvalid = r_vld[1];
  assign all_settled   = ~|moving;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [DW-1:0] w_tgt;
    logic signed [DW-1:0] w_in;
    logic signed [DW-1:0] w_nxt;
    logic signed [DW-1:0] r_off;
    logic signed [DW-1:0] r_out;
    logic signed [DW:0]   w_off_e;
    logic signed [DW:0]   w_tgt_e;
    logic signed [DW:0]   w_stp_e;
    logic signed [DW:0]   w_up;
    logic signed [DW:0]   w_dn;
    logic signed [DW+1:0] w_mod_e;
    logic signed [DW+1:0] w_sum;
    logic                 w_unused_stp;
    state_t               r_state;
    logic                 r_done;

    assign w_tgt        = target[k*DW +: DW];
    assign w_in         = r_in[k*DW +: DW];
    assign w_off_e      = {r_off[DW-1], r_off};
    assign w_tgt_e      = {w_tgt[DW-1], w_tgt};
    assign w_stp_e      = {2'b00, step[k*DW +: DW-1]};
    assign w_unused_stp = step[k*DW+DW-1];
    // One extra bit keeps off +/- step from wrapping near full scale.
    assign w_up         = w_off_e + w_stp_e;
    assign w_dn         = w_off_e - w_stp_e;

    always_comb begin
      if (w_stp_e == '0)       w_nxt = w_tgt;
      else if (w_tgt_e > w_up) w_nxt = w_up[DW-1:0];
      else if (w_tgt_e < w_dn) w_nxt = w_dn[DW-1:0];
      else                     w_nxt = w_tgt;
    end

    // A move that lands on target in the same tick it starts still reports one done pulse.
    always_ff @(posedge a_clk) begin
      if (a_rst) begin
        r_off   <= '0;
        r_state <= ST_SETTLED;
        r_done  <= 1'b0;
      end else begin
        r_done <= 1'b0;
        if (w_tick && !hold) begin
          r_off <= w_nxt;
          if (w_nxt != w_tgt) begin
            r_state <= ST_MOVING;
          end else begin
            r_state <= ST_SETTLED;
            r_done  <= (r_state == ST_MOVING) || (r_off != w_tgt);
          end
        end
      end
    end

    assign w_mod_e = mod_mask[k] ? {{2{r_mod[DW-1]}}, r_mod} : '0;
    assign w_sum   = {{2{r_off[DW-1]}}, r_off} + {{2{w_in[DW-1]}}, w_in} + w_mod_e;

    always_ff @(posedge a_clk) begin
      if (a_rst)                r_out <= '0;
      else if (w_sum > SAT_MAX) r_out <= SAT_MAX[DW-1:0];
      else if (w_sum < SAT_MIN) r_out <= SAT_MIN[DW-1:0];
      else                      r_out <= w_sum[DW-1:0];
    end

    assign offset_mon[k*DW +: DW]   = r_off;
    assign m_axis_tdata[k*DW +: DW] = r_out;
    assign moving[k]                = (r_state == ST_MOVING);
    assign done[k]                  = r_done;
  end

endmodule
